// File: rtl/rect_fill_scheduler.sv
// rect_fill_scheduler: grants clear/draw jobs and scans the job
// rectangle in raster order, one registered framebuffer write per clock.
module rect_fill_scheduler #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_req,
    input  logic [23:0] clear_color,
    output logic        clear_done,
    input  logic        draw_req,
    input  logic [9:0]  draw_x,
    input  logic [8:0]  draw_y,
    input  logic [9:0]  draw_w,
    input  logic [8:0]  draw_h,
    input  logic [23:0] draw_color,
    output logic        draw_ack,
    output logic        busy,
    output logic [9:0]  write_x,
    output logic [8:0]  write_y,
    output logic [23:0] write_color,
    output logic        wren
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [10:0] SW = 11'(SCREEN_W);
    localparam logic [9:0]  SH = 10'(SCREEN_H);

    logic [1:0]  state;
    logic [10:0] x0;
    logic [10:0] x_end;
    logic [10:0] cur_x;
    logic [9:0]  y_end;
    logic [9:0]  cur_y;
    logic [23:0] color;
    logic        job_clear;
    logic        fill_done;

    logic [10:0] nxt_x;
    logic [9:0]  nxt_y;
    logic        on_screen;

    // Extra coordinate bit keeps x0+w / y0+h from wrapping.
    assign nxt_x     = cur_x + 11'd1;
    assign nxt_y     = cur_y + 10'd1;
    assign on_screen = (cur_x < SW) && (cur_y < SH);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            x0          <= '0;
            x_end       <= '0;
            cur_x       <= '0;
            y_end       <= '0;
            cur_y       <= '0;
            color       <= '0;
            job_clear   <= 1'b0;
            fill_done   <= 1'b0;
            write_x     <= '0;
            write_y     <= '0;
            write_color <= '0;
            wren        <= 1'b0;
            draw_ack    <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            wren       <= 1'b0;
            draw_ack   <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state     <= S_FILL;
                        job_clear <= 1'b1;
                        x0        <= '0;
                        cur_x     <= '0;
                        cur_y     <= '0;
                        x_end     <= SW;
                        y_end     <= SH;
                        color     <= clear_color;
                        fill_done <= (SW == '0) || (SH == '0);
                    end else if (draw_req) begin
                        state     <= S_FILL;
                        job_clear <= 1'b0;
                        x0        <= {1'b0, draw_x};
                        cur_x     <= {1'b0, draw_x};
                        cur_y     <= {1'b0, draw_y};
                        x_end     <= {1'b0, draw_x} + {1'b0, draw_w};
                        y_end     <= {1'b0, draw_y} + {1'b0, draw_h};
                        color     <= draw_color;
                        fill_done <= (draw_w == '0) || (draw_h == '0);
                    end
                end
                S_FILL: begin
                    if (fill_done) begin
                        state      <= S_ACK;
                        draw_ack   <= !job_clear;
                        clear_done <= job_clear;
                    end else begin
                        write_x     <= cur_x[9:0];
                        write_y     <= cur_y[8:0];
                        write_color <= color;
                        wren        <= on_screen;
                        if (nxt_x == x_end) begin
                            cur_x <= x0;
                            cur_y <= nxt_y;
                            if (nxt_y == y_end) begin
                                fill_done <= 1'b1;
                            end
                        end else begin
                            cur_x <= nxt_x;
                        end
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_scheduler.sv
// tb_rect_fill_scheduler: scenario tasks compared against a raster-order
// reference model of expected writes and ack timing.
module tb_rect_fill_scheduler;

    localparam int SW = 160;
    localparam int SH = 120;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear_req = 1'b0;
    logic [23:0] clear_color = '0;
    logic        clear_done;
    logic        draw_req = 1'b0;
    logic [9:0]  draw_x = '0;
    logic [8:0]  draw_y = '0;
    logic [9:0]  draw_w = '0;
    logic [8:0]  draw_h = '0;
    logic [23:0] draw_color = '0;
    logic        draw_ack;
    logic        busy;
    logic [9:0]  write_x;
    logic [8:0]  write_y;
    logic [23:0] write_color;
    logic        wren;

    int tests = 0;
    int fails = 0;

    int          ex_k[$];
    int          ex_x[$];
    int          ex_y[$];
    logic [23:0] ex_c[$];
    int          ob_k[$];
    int          ob_x[$];
    int          ob_y[$];
    logic [23:0] ob_c[$];
    int          ack_k[$];
    bit          ack_clr[$];
    bit          bsy[$];
    bit          busy_after;
    bit          wren_after;
    bit          timeout;

    rect_fill_scheduler #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk),
        .reset(reset),
        .clear_req(clear_req),
        .clear_color(clear_color),
        .clear_done(clear_done),
        .draw_req(draw_req),
        .draw_x(draw_x),
        .draw_y(draw_y),
        .draw_w(draw_w),
        .draw_h(draw_h),
        .draw_color(draw_color),
        .draw_ack(draw_ack),
        .busy(busy),
        .write_x(write_x),
        .write_y(write_y),
        .write_color(write_color),
        .wren(wren)
    );

    always #5 clk = ~clk;

    // Expected visible writes of one job whose grant edge is k0 cycles in.
    task automatic model_job(input int x, input int y, input int w,
                             input int h, input logic [23:0] c,
                             input int k0, output int n);
        n = 0;
        for (int yy = y; yy < y + h; yy++) begin
            for (int xx = x; xx < x + w; xx++) begin
                n++;
                if (xx < SW && yy < SH) begin
                    ex_k.push_back(k0 + n);
                    ex_x.push_back(xx);
                    ex_y.push_back(yy);
                    ex_c.push_back(c);
                end
            end
        end
    endtask

    function automatic int first_diff();
        int n = ex_k.size();
        if (ob_k.size() < n) n = ob_k.size();
        for (int i = 0; i < n; i++) begin
            if (ob_k[i] != ex_k[i] || ob_x[i] != ex_x[i] ||
                ob_y[i] != ex_y[i] || ob_c[i] !== ex_c[i])
                return i;
        end
        if (ob_k.size() != ex_k.size()) return n;
        return -1;
    endfunction

    task automatic clear_q();
        ex_k.delete(); ex_x.delete(); ex_y.delete(); ex_c.delete();
    endtask

    // Samples every cycle after the edge that follows the request setup.
    task automatic collect(input int max_k, input int n_acks,
                           input int drop_at, input bit scramble);
        int draws;
        draws = 0;
        ob_k.delete(); ob_x.delete(); ob_y.delete(); ob_c.delete();
        ack_k.delete(); ack_clr.delete(); bsy.delete();
        timeout = 0;
        for (int k = 0; k <= max_k; k++) begin
            @(negedge clk);
            bsy.push_back(busy);
            if (scramble && k == 1) begin
                draw_x = 10'($urandom); draw_y = 9'($urandom);
                draw_w = 10'($urandom); draw_h = 9'($urandom);
                draw_color = 24'($urandom);
            end
            if (wren) begin
                ob_k.push_back(k); ob_x.push_back(int'(write_x));
                ob_y.push_back(int'(write_y)); ob_c.push_back(write_color);
            end
            if (clear_done) begin
                ack_k.push_back(k); ack_clr.push_back(1);
                clear_req = 1'b0;
            end
            if (draw_ack) begin
                ack_k.push_back(k); ack_clr.push_back(0);
                draws++;
                if (draws == drop_at) draw_req = 1'b0;
            end
            if (ack_k.size() >= n_acks) break;
        end
        if (ack_k.size() < n_acks) timeout = 1;
        draw_req = 1'b0;
        clear_req = 1'b0;
        @(negedge clk);
        busy_after = busy;
        wren_after = wren;
    endtask

    task automatic start_draw(input int x, input int y, input int w,
                              input int h, input logic [23:0] c);
        @(negedge clk);
        draw_x = 10'(x); draw_y = 9'(y);
        draw_w = 10'(w); draw_h = 9'(h);
        draw_color = c;
        draw_req = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({wren, busy, draw_ack, clear_done} !== 4'b0 ||
            write_x !== '0 || write_y !== '0 || write_color !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got wren=%b busy=%b ack=%b done=%b x=%0d y=%0d c=%h, required all 0",
                     wren, busy, draw_ack, clear_done, write_x, write_y, write_color);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic_draw();
        int n, idx;
        clear_q();
        model_job(10, 20, 2, 2, 24'hFF0000, 0, n);
        start_draw(10, 20, 2, 2, 24'hFF0000);
        collect(50, 1, 1, 1);
        idx = first_diff();
        tests++;
        if (idx != -1) begin
            fails++;
            $display("FAIL basic_writes: diff at %0d, got %0d writes, required %0d",
                     idx, ob_k.size(), ex_k.size());
        end
        tests++;
        if (timeout || ack_k[0] != n + 1 || ack_clr[0] != 0) begin
            fails++;
            $display("FAIL basic_ack: got %0d acks, required draw_ack at cycle %0d",
                     ack_k.size(), n + 1);
        end
        tests++;
        if (bsy[0] !== 1'b1 || busy_after !== 1'b0 || wren_after !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy: grant busy=%b after busy=%b wren=%b, required 1 0 0",
                     bsy[0], busy_after, wren_after);
        end
        @(negedge clk);
        tests++;
        if (write_x !== 10'd11 || write_y !== 9'd21 || write_color !== 24'hFF0000) begin
            fails++;
            $display("FAIL idle_hold: got (%0d,%0d,%h), required (11,21,ff0000)",
                     write_x, write_y, write_color);
        end
    endtask

    task automatic test_clip_corner();
        int n, idx;
        clear_q();
        model_job(SW - 1, SH - 1, 2, 2, 24'h00FF00, 0, n);
        start_draw(SW - 1, SH - 1, 2, 2, 24'h00FF00);
        collect(50, 1, 1, 0);
        idx = first_diff();
        tests++;
        if (idx != -1 || ob_k.size() != 1) begin
            fails++;
            $display("FAIL clip_writes: got %0d writes, required %0d", ob_k.size(), ex_k.size());
        end
        tests++;
        if (timeout || ack_k[0] != 5) begin
            fails++;
            $display("FAIL clip_ack: got %0d acks, required ack at cycle 5", ack_k.size());
        end
    endtask

    task automatic test_empty();
        start_draw(30, 40, 0, 5, 24'h123456);
        collect(20, 1, 1, 0);
        tests++;
        if (timeout || ob_k.size() != 0 || ack_k[0] != 1) begin
            fails++;
            $display("FAIL empty_w0: got %0d writes %0d acks, required 0 writes ack at cycle 1",
                     ob_k.size(), ack_k.size());
        end
        start_draw(30, 40, 3, 0, 24'h654321);
        collect(20, 1, 1, 0);
        tests++;
        if (timeout || ob_k.size() != 0 || ack_k[0] != 1) begin
            fails++;
            $display("FAIL empty_h0: got %0d writes %0d acks, required 0 writes ack at cycle 1",
                     ob_k.size(), ack_k.size());
        end
    endtask

    task automatic test_no_wrap();
        start_draw(1020, 508, 6, 6, 24'hABCDEF);
        collect(80, 1, 1, 0);
        tests++;
        if (timeout || ob_k.size() != 0 || ack_k[0] != 37) begin
            fails++;
            $display("FAIL no_wrap: got %0d writes %0d acks, required 0 writes ack at cycle 37",
                     ob_k.size(), ack_k.size());
        end
    endtask

    task automatic test_clear_then_draw();
        int nc, nd, idx;
        clear_q();
        model_job(0, 0, SW, SH, 24'h0000AA, 0, nc);
        model_job(5, 6, 3, 2, 24'h55AA55, nc + 3, nd);
        @(negedge clk);
        clear_color = 24'h0000AA;
        draw_x = 10'd5; draw_y = 9'd6; draw_w = 10'd3; draw_h = 9'd2;
        draw_color = 24'h55AA55;
        clear_req = 1'b1;
        draw_req = 1'b1;
        collect(SW * SH + 100, 2, 1, 0);
        idx = first_diff();
        tests++;
        if (idx != -1) begin
            fails++;
            $display("FAIL clear_writes: diff at %0d, got %0d writes, required %0d",
                     idx, ob_k.size(), ex_k.size());
        end
        tests++;
        if (timeout || ack_clr[0] != 1 || ack_k[0] != nc + 1) begin
            fails++;
            $display("FAIL clear_done: got %0d acks, required clear_done at cycle %0d",
                     ack_k.size(), nc + 1);
        end
        tests++;
        if (timeout || ack_clr[1] != 0 || ack_k[1] != nc + nd + 4) begin
            fails++;
            $display("FAIL clear_draw_ack: got %0d acks, required draw_ack at cycle %0d",
                     ack_k.size(), nc + nd + 4);
        end
    endtask

    task automatic test_back_to_back();
        int n, n2, idx;
        clear_q();
        model_job(100, 50, 3, 3, 24'hC0FFEE, 0, n);
        model_job(100, 50, 3, 3, 24'hC0FFEE, n + 3, n2);
        start_draw(100, 50, 3, 3, 24'hC0FFEE);
        collect(100, 2, 2, 0);
        idx = first_diff();
        tests++;
        if (idx != -1) begin
            fails++;
            $display("FAIL b2b_writes: diff at %0d, got %0d writes, required %0d",
                     idx, ob_k.size(), ex_k.size());
        end
        tests++;
        if (timeout || ack_k[0] != n + 1 || ack_k[1] != n + n2 + 4) begin
            fails++;
            $display("FAIL b2b_acks: got %0d acks, required at cycles %0d and %0d",
                     ack_k.size(), n + 1, n + n2 + 4);
        end
        tests++;
        if (timeout || bsy[n + 2] !== 1'b0 || bsy[n + 3] !== 1'b1 || busy_after !== 1'b0) begin
            fails++;
            $display("FAIL b2b_busy: got %0d acks, required busy 0 then 1 around regrant, 0 after",
                     ack_k.size());
        end
    endtask

    task automatic test_random();
        int x, y, w, h, n, idx;
        logic [23:0] c;
        for (int j = 0; j < 8; j++) begin
            x = $urandom_range(0, SW + 5);
            y = $urandom_range(0, SH + 5);
            if (j < 3) begin
                x = SW - int'($urandom_range(1, 3));
                y = SH - int'($urandom_range(1, 3));
            end
            w = $urandom_range(0, 6);
            h = $urandom_range(0, 5);
            c = 24'($urandom);
            clear_q();
            model_job(x, y, w, h, c, 0, n);
            start_draw(x, y, w, h, c);
            collect(80, 1, 1, 1);
            idx = first_diff();
            tests++;
            if (idx != -1 || timeout || ack_k[0] != n + 1 || busy_after !== 1'b0) begin
                fails++;
                $display("FAIL rand_job%0d (%0d,%0d,%0dx%0d): %0d writes (required %0d), %0d acks",
                         j, x, y, w, h, ob_k.size(), ex_k.size(), ack_k.size());
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int seen;
        bit stray;
        seen = 0;
        start_draw(50, 60, 4, 4, 24'h0F0F0F);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (wren) seen++;
        end
        tests++;
        if (seen != 3) begin
            fails++;
            $display("FAIL rst_pre_writes: got %0d, required 3", seen);
        end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({wren, busy, draw_ack, clear_done} !== 4'b0 ||
            write_x !== '0 || write_y !== '0 || write_color !== '0) begin
            fails++;
            $display("FAIL rst_async: got wren=%b busy=%b ack=%b x=%0d y=%0d c=%h, required all 0",
                     wren, busy, draw_ack, write_x, write_y, write_color);
        end
        draw_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy || wren || draw_ack || clear_done) stray = 1;
        end
        tests++;
        if (stray) begin
            fails++;
            $display("FAIL rst_stays_idle: activity seen=1, required 0");
        end
    endtask

    initial begin
        test_reset();
        test_basic_draw();
        test_clip_corner();
        test_empty();
        test_no_wrap();
        test_clear_then_draw();
        test_back_to_back();
        test_random();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
